// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder over a word array.
// Define DMEM_WAIT_STATE_EN to insert WAIT_CYCLES wait states before each response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif
  state_t state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic alive_q, alive_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, in_range;
  logic [AW-1:0] widx;
  logic unused_ok;
  assign unused_ok = ^{req_addr[1:0], 4'(WAIT_CYCLES)};
  assign accept = req_valid && req_ready;
  assign in_range = {2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS);
  assign widx = req_addr[AW+1:2];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      alive_q <= alive_d;
`ifdef DMEM_WAIT_STATE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  // Storage is deliberately unreset; a store commits at its accept edge.
  always_ff @(posedge clk) begin
    if (accept && req_write && in_range)
      for (int i = 0; i < 4; i++)
        if (req_wstrb[i]) mem[widx][8*i +: 8] <= req_wdata[8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
`ifdef DMEM_WAIT_STATE_EN
    cnt_d = cnt_q;
`endif
    unique case (state_q)
      IDLE: if (accept) begin
`ifdef DMEM_WAIT_STATE_EN
        state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        cnt_d = '0;
`else
        state_d = RESP;
`endif
      end
`ifdef DMEM_WAIT_STATE_EN
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(WAIT_CYCLES - 1)) state_d = RESP;
      end
`endif
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    alive_d = 1'b1;
    err_d   = accept ? !in_range : err_q;
    rdata_d = accept ? ((!req_write && in_range) ? mem[widx] : '0) : rdata_q;
  end
  always_comb begin
    req_ready = alive_q && (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder.
module tb_data_mem_responder;
  localparam int DW = 1024;
`ifdef DMEM_WAIT_STATE_EN
  localparam int WC = 3;
`else
  localparam int WC = 0;
`endif
  localparam int LAT = 1 + WC;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] model [DW];
  logic [32:0] sb [$];
  int nchk = 0, nfail = 0;
  data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    logic [32:0] exp;
    bit inr;
    int n;
    inr = a[31:2] < DW;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {32'b0, req_ready}, 33'd1);
    exp = {(inr && !w) ? model[a[11:2]] : 32'h0, !inr};
    if (w && inr)
      for (int i = 0; i < 4; i++)
        if (s[i]) model[a[11:2]][8*i +: 8] = d[8*i +: 8];
    sb.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk("wait_no_valid", {32'b0, rsp_valid}, 33'd0);
      @(posedge clk); #1;
    end
    chk("rsp_valid", {32'b0, rsp_valid}, 33'd1);
    chk("busy_ready", {32'b0, req_ready}, 33'd0);
    exp = sb.pop_front();
    chk("rsp_data_err", {rsp_rdata, rsp_err}, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", {32'b0, rsp_valid}, 33'd1);
      chk("hold_data_err", {rsp_rdata, rsp_err}, exp);
      chk("hold_ready", {32'b0, req_ready}, 33'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", {32'b0, rsp_valid}, 33'd0);
    chk("ready_back", {32'b0, req_ready}, 33'd1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {32'b0, req_ready}, 33'd0);
    chk("rst_valid", {32'b0, rsp_valid}, 33'd0);
    chk("rst_data_err", {rsp_rdata, rsp_err}, 33'd0);
    rstn = 1'b1;
    #1;
    chk("pre_edge_ready", {32'b0, req_ready}, 33'd0);
    @(posedge clk); #1;
    chk("post_edge_ready", {32'b0, req_ready}, 33'd1);
    xact(1, 32'h0, 32'h12345678, 4'hF, 0);
    xact(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 0);
    xact(1, 32'h10, 32'h000000AA, 4'b0001, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 0);
    xact(1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
    xact(0, 32'h13, 32'h0, 4'h0, 5);
    xact(1, 32'h10, 32'h11223344, 4'b1010, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 2);
    xact(0, 32'h1000, 32'h0, 4'h0, 1);
    xact(1, 32'h1000, 32'hBAD0BAD0, 4'hF, 0);
    xact(0, 32'h0, 32'h0, 4'h0, 0);
    xact(0, 32'hFFFFFFFC, 32'h0, 4'h0, 0);
    xact(1, 32'hFFC, 32'hA5A5_0F0F, 4'hF, 0);
    xact(0, 32'hFFC, 32'h0, 4'h0, 0);
    for (int i = 0; i < 8; i++) xact(1, 32'h100 + 32'(4*i), $urandom, 4'hF, 0);
    for (int i = 0; i < 16; i++)
      xact(1'($urandom_range(0, 1)), 32'h100 + 32'(4*$urandom_range(0, 7)),
           $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    // Store is accepted, then reset hits before its response is consumed.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    chk("rst_store_ready", {32'b0, req_ready}, 33'd1);
    model[8] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {32'b0, rsp_valid}, 33'd0);
    chk("mid_rst_ready", {32'b0, req_ready}, 33'd0);
    chk("mid_rst_data_err", {rsp_rdata, rsp_err}, 33'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_valid", {32'b0, rsp_valid}, 33'd0);
    chk("after_rst_ready", {32'b0, req_ready}, 33'd1);
    xact(0, 32'h20, 32'h0, 4'h0, 0);
    xact(0, 32'h0, 32'h0, 4'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
